layer2_forward: RTL and testbench

LAYER2_FORWARD -- requirements
Module: layer2_forward

---
 rtl/dqn_pkg.sv | 33 +++
 rtl/layer2_forward_if.sv | 30 +++
 rtl/mac_lane.sv | 56 +++++
 rtl/layer2_forward.sv | 131 +++++++++++++
 tb/tb_layer2_forward.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dqn_pkg.sv
// Shared types and sizing for the DQN output layer (Q8.8 data, 32-bit accumulators).
// Latency: n/a (declarations and a combinational argmax helper only).
// Backpressure: n/a.
package dqn_pkg;

  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int N_HIDDEN = 9;
  localparam int N_OUT    = 5;
  localparam int ACC_W    = 32;

  // FSM encoding kept as plain constants so older tools can consume it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  // Index of the largest signed element; strict compare keeps the lowest index on ties.
  function automatic logic [2:0] argmax(input logic [N_OUT-1:0][DATA_W-1:0] v);
    logic [2:0]               best;
    logic signed [DATA_W-1:0] best_v;
    best   = 3'd0;
    best_v = $signed(v[0]);
    for (int i = 1; i < N_OUT; i++) begin
      if ($signed(v[i]) > best_v) begin
        best_v = $signed(v[i]);
        best   = 3'(i);
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/layer2_forward_if.sv
// Bundle of the layer2_forward data/control signals: start, hidden inputs, weight row, results.
// Latency: n/a (wires only).
// Backpressure: none; start is a request level sampled by the engine only when it is idle.
interface layer2_forward_if;
  import dqn_pkg::*;

  logic                     start;
  logic signed [DATA_W-1:0] h_1, h_2, h_3, h_4, h_5, h_6, h_7, h_8, h_9;
  logic [3:0]               ctrl;
  logic signed [DATA_W-1:0] w2_1, w2_2, w2_3, w2_4, w2_5;
  logic signed [DATA_W-1:0] q_1, q_2, q_3, q_4, q_5;
  logic [2:0]               action;
  logic                     busy;
  logic                     done;

  // Requester side: issues start, supplies activations and the weight store read data.
  modport master (
    output start, h_1, h_2, h_3, h_4, h_5, h_6, h_7, h_8, h_9,
    output w2_1, w2_2, w2_3, w2_4, w2_5,
    input  ctrl, q_1, q_2, q_3, q_4, q_5, action, busy, done
  );

  // Engine side.
  modport slave (
    input  start, h_1, h_2, h_3, h_4, h_5, h_6, h_7, h_8, h_9,
    input  w2_1, w2_2, w2_3, w2_4, w2_5,
    output ctrl, q_1, q_2, q_3, q_4, q_5, action, busy, done
  );

endinterface

// File: rtl/mac_lane.sv
// One output lane: acc += (h*w)>>>FRAC_W per enabled cycle, reduced to 16 bits (SATURATE_EN clamps, else wraps).
// Latency: 1 cycle per accumulate; reduced value is combinational from the accumulator.
// Backpressure: none; clr has priority over en.
module mac_lane
  import dqn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] h,
  input  logic signed [DATA_W-1:0] w,
  output logic signed [DATA_W-1:0] red
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] h_x, w_x, prod;

  // Full-precision signed product, rescaled back to Q8.8 and accumulated.
  always_comb begin
    h_x   = ACC_W'(h);
    w_x   = ACC_W'(w);
    prod  = h_x * w_x;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + (prod >>> FRAC_W);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Narrow the accumulator to the output format.
  always_comb begin
`ifdef SATURATE_EN
    if (acc_q > ACC_W'(32'sd32767)) begin
      red = 16'sh7FFF;
    end else if (acc_q < ACC_W'(-32'sd32768)) begin
      red = 16'sh8000;
    end else begin
      red = acc_q[DATA_W-1:0];
    end
`else
    red = acc_q[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/layer2_forward.sv
// Output layer of the Q-network: 9x5 Q8.8 dot products via five mac_lane instances, then argmax (SATURATE_EN selects clamping).
// Latency: start sampled at the end of cycle T -> q/action/done appear in cycle T+11; 12-cycle pass period.
// Backpressure: start ignored while busy and in the done cycle; results hold until the next pass completes.
module layer2_forward
  import dqn_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  layer2_forward_if.slave io
);

  state_t                       state_q, state_d;
  logic [3:0]                   idx_q, idx_d;
  logic signed [DATA_W-1:0]     h_q [N_HIDDEN];
  logic signed [DATA_W-1:0]     h_d [N_HIDDEN];
  logic [N_OUT-1:0][DATA_W-1:0] q_q, q_d, red;
  logic [2:0]                   action_q, action_d;
  logic                         done_q, done_d;
  logic                         clr, en;
  logic signed [DATA_W-1:0]     h_sel;
  logic signed [DATA_W-1:0]     w_row [N_OUT];

  // Sequencer: latch inputs on start, walk 9 rows, then publish results from FIN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    h_d      = h_q;
    q_d      = q_q;
    action_d = action_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The done cycle is not a start slot, so consumers always see a
        // full result cycle before the next pass begins.
        if (io.start && !done_q) begin
          state_d = ST_RUN;
          idx_d   = 4'd0;
          clr     = 1'b1;
          h_d[0]  = io.h_1;
          h_d[1]  = io.h_2;
          h_d[2]  = io.h_3;
          h_d[3]  = io.h_4;
          h_d[4]  = io.h_5;
          h_d[5]  = io.h_6;
          h_d[6]  = io.h_7;
          h_d[7]  = io.h_8;
          h_d[8]  = io.h_9;
        end
      end
      ST_RUN: begin
        en = 1'b1;
        if (idx_q == 4'(N_HIDDEN - 1)) begin
          state_d = ST_FIN;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_FIN: begin
        state_d  = ST_IDLE;
        q_d      = red;
        action_d = argmax(red);
        done_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched activations and published results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      q_q      <= '0;
      action_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_HIDDEN; i++) begin
        h_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      q_q      <= q_d;
      action_q <= action_d;
      done_q   <= done_d;
      h_q      <= h_d;
    end
  end

  // Row operands shared by all lanes: the current activation and its weight row.
  always_comb begin
    h_sel = '0;
    if (idx_q < 4'(N_HIDDEN)) begin
      h_sel = h_q[idx_q];
    end
    w_row[0] = io.w2_1;
    w_row[1] = io.w2_2;
    w_row[2] = io.w2_3;
    w_row[3] = io.w2_4;
    w_row[4] = io.w2_5;
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    mac_lane u_lane (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .h   (h_sel),
      .w   (w_row[g]),
      .red (red[g])
    );
  end

  // Row address only meaningful while running; parked at 0 otherwise.
  always_comb begin
    io.ctrl   = (state_q == ST_RUN) ? idx_q : 4'd0;
    io.busy   = (state_q != ST_IDLE);
    io.done   = done_q;
    io.action = action_q;
    io.q_1    = q_q[0];
    io.q_2    = q_q[1];
    io.q_3    = q_q[2];
    io.q_4    = q_q[3];
    io.q_5    = q_q[4];
  end

endmodule

// File: tb/tb_layer2_forward.sv
// Scoreboard bench for layer2_forward: directed passes push expected results, a monitor checks on done.
// Latency: expects done 11 cycles after the cycle start is driven.
// Backpressure: none; the bench models the weight store as a combinational lookup on ctrl.
module tb_layer2_forward;

  typedef struct {
    logic [15:0] q[5];
    logic [2:0]  act;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] wmem [9][5];
  int          run_idx   = 0;
  int          last_len  = 0;
  logic        prev_busy = 1'b0;

  layer2_forward_if bus();

  layer2_forward dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight store: row selected by ctrl, returned combinationally.
  always_comb begin
    bus.w2_1 = '0;
    bus.w2_2 = '0;
    bus.w2_3 = '0;
    bus.w2_4 = '0;
    bus.w2_5 = '0;
    if (bus.ctrl < 4'd9) begin
      bus.w2_1 = wmem[bus.ctrl][0];
      bus.w2_2 = wmem[bus.ctrl][1];
      bus.w2_3 = wmem[bus.ctrl][2];
      bus.w2_4 = wmem[bus.ctrl][3];
      bus.w2_5 = wmem[bus.ctrl][4];
    end
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] qv(input int j);
    case (j)
      0:       return bus.q_1;
      1:       return bus.q_2;
      2:       return bus.q_3;
      3:       return bus.q_4;
      default: return bus.q_5;
    endcase
  endfunction

  task automatic set_h(input logic [15:0] hv[9]);
    bus.h_1 = hv[0]; bus.h_2 = hv[1]; bus.h_3 = hv[2];
    bus.h_4 = hv[3]; bus.h_5 = hv[4]; bus.h_6 = hv[5];
    bus.h_7 = hv[6]; bus.h_8 = hv[7]; bus.h_9 = hv[8];
  endtask

  task automatic set_h_all(input logic [15:0] v);
    logic [15:0] hv[9];
    foreach (hv[i]) hv[i] = v;
    set_h(hv);
  endtask

  task automatic set_w_rows(input logic [15:0] wv[5]);
    for (int r = 0; r < 9; r++)
      for (int j = 0; j < 5; j++)
        wmem[r][j] = wv[j];
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout @cyc %0d: %0d results outstanding, required 0", cyc, sb.size());
      sb.delete();
    end
  endtask

  // One pass: queue the expectation, pulse start, wait for the monitor, then confirm the results hold.
  task automatic run_pass(input logic [15:0] eq[5], input logic [2:0] ea);
    exp_t e;
    @(posedge clk); #1;
    e.q   = eq;
    e.act = ea;
    e.cyc = cyc + 11;
    sb.push_back(e);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain(40);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 5; j++) chk16("q_hold", qv(j), eq[j]);
    chki("action_hold", bus.action, ea);
  endtask

  // Monitor: ctrl walk while busy, ctrl parked when idle, results and timing on done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        chki("ctrl_seq", bus.ctrl, (run_idx < 9) ? run_idx : 0);
        run_idx++;
      end else begin
        chki("ctrl_idle", bus.ctrl, 0);
        if (prev_busy) last_len = run_idx;
        run_idx = 0;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done @cyc %0d: got done=1 required 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          chki("done_cycle", cyc, mon_e.cyc);
          chki("busy_len", last_len, 10);
          for (int j = 0; j < 5; j++) chk16("q_val", qv(j), mon_e.q[j]);
          chki("action", bus.action, mon_e.act);
        end
      end
      prev_busy = bus.busy;
    end else begin
      run_idx   = 0;
      prev_busy = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [15:0] eq[5];
    logic [15:0] wv[5];
    logic [15:0] hv[9];

    rst       = 1'b1;
    bus.start = 1'b0;
    set_h_all(16'h0000);
    wv = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    set_w_rows(wv);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int j = 0; j < 5; j++) chk16("rst_q", qv(j), 16'h0000);
    chki("rst_action", bus.action, 0);
    chki("rst_busy", bus.busy, 0);
    chki("rst_done", bus.done, 0);
    chki("rst_ctrl", bus.ctrl, 0);

    // Unit activations and weights: 9 * 1.0.
    set_h_all(16'h0100);
    wv = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    set_w_rows(wv);
    eq = '{16'h0900, 16'h0900, 16'h0900, 16'h0900, 16'h0900};
    run_pass(eq, 3'd0);

    // Tie between outputs 3 and 5 resolves to the lower index.
    wv = '{16'h0100, 16'h0100, 16'h0200, 16'h0100, 16'h0200};
    set_w_rows(wv);
    eq = '{16'h0900, 16'h0900, 16'h1200, 16'h0900, 16'h1200};
    run_pass(eq, 3'd2);

    // Full-scale operands: 9 * 0x3FFF00 = 0x23FF700.
    set_h_all(16'h7FFF);
    wv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    set_w_rows(wv);
`ifdef SATURATE_EN
    eq = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
`else
    eq = '{16'hF700, 16'hF700, 16'hF700, 16'hF700, 16'hF700};
`endif
    run_pass(eq, 3'd0);

    // Negative activation: -1*3 = -3, -1*1 = -1, -1*-1 = +1.
    hv = '{16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    set_h(hv);
    wv = '{16'h0300, 16'h0100, 16'h0100, 16'hFF00, 16'h0100};
    set_w_rows(wv);
    eq = '{16'hFD00, 16'hFF00, 16'hFF00, 16'h0100, 16'hFF00};
    run_pass(eq, 3'd3);

    // Row-dependent weights pin the ctrl/row pairing: q1=h9, q2=h1, q3=2*h5.
    hv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
           16'h0600, 16'h0700, 16'h0800, 16'h0900};
    set_h(hv);
    wv = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    set_w_rows(wv);
    wmem[8][0] = 16'h0100;
    wmem[0][1] = 16'h0100;
    wmem[4][2] = 16'h0200;
    eq = '{16'h0900, 16'h0100, 16'h0A00, 16'h0000, 16'h0000};
    run_pass(eq, 3'd2);

    // Reset at RUN index 4 aborts the pass without a done pulse.
    set_h_all(16'h0100);
    wv = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    set_w_rows(wv);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chki("abort_busy", bus.busy, 0);
    chki("abort_done", bus.done, 0);
    chki("abort_ctrl", bus.ctrl, 0);
    chki("abort_action", bus.action, 0);
    for (int j = 0; j < 5; j++) chk16("abort_q", qv(j), 16'h0000);
    repeat (15) @(posedge clk);
    eq = '{16'h0900, 16'h0900, 16'h0900, 16'h0900, 16'h0900};
    run_pass(eq, 3'd0);

    // Start held high: accepted every 12 cycles.
    wv = '{16'h0100, 16'h0200, 16'h0100, 16'h0100, 16'h0100};
    set_w_rows(wv);
    eq = '{16'h0900, 16'h1200, 16'h0900, 16'h0900, 16'h0900};
    @(posedge clk); #1;
    n0 = cyc;
    for (int k = 0; k < 3; k++) begin
      mon_e.q   = eq;
      mon_e.act = 3'd1;
      mon_e.cyc = n0 + 11 + 12 * k;
      sb.push_back(mon_e);
    end
    bus.start = 1'b1;
    repeat (25) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_drain(60);
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
